// File: rtl/soc_pkg.sv
// Shared SOC definitions: display controller register offsets, scan states
// and the all-segments-off pattern.
package soc_pkg;

  localparam logic [3:0] SEG_LED_OFS  = 4'h0;
  localparam logic [3:0] SEG_DIG_OFS  = 4'h4;
  localparam logic [3:0] SEG_CTRL_OFS = 4'h8;
  localparam logic [3:0] SEG_STAT_OFS = 4'hC;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SEG_OFF,
    SEG_DRIVE,
    SEG_GAP
  } seg_state_e;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern (bit0=a .. bit6=g).
module hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped LED and 4-digit multiplexed seven-segment controller with
// inter-digit ghost gap and frame-boundary commit of the digit register.
module seg_display_ctrl
  import soc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_CYC  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  seg_state_e    state_q, state_d;
  logic [15:0]   led_q, led_d;
  logic [15:0]   stage_q, stage_d;
  logic [15:0]   active_q, active_d;
  logic          en_q, en_d;
  logic [3:0]    blank_q, blank_d;
  logic          pend_q, pend_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [31:0]   rdata_q, rdata_d;

  logic       wr, rd, dig_wr, commit;
  logic [3:0] ofs;
  logic [3:0] nib;
  logic [6:0] dec;

  hex7seg u_hex7seg (
    .hex (nib),
    .seg (dec)
  );

  always_comb begin
    led_d    = led_q;
    stage_d  = stage_q;
    active_d = active_q;
    en_d     = en_q;
    blank_d  = blank_q;
    pend_d   = pend_q;
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    commit   = 1'b0;

    ofs    = {addr[3:2], 2'b00};
    wr     = sel & we;
    rd     = sel & ~we;
    dig_wr = wr && (ofs == SEG_DIG_OFS);

    if (wr) begin
      case (ofs)
        SEG_LED_OFS:  led_d = wdata[15:0];
        SEG_DIG_OFS:  stage_d = wdata[15:0];
        SEG_CTRL_OFS: begin
          en_d    = wdata[0];
          blank_d = wdata[7:4];
        end
        default: ;
      endcase
    end
    if (dig_wr) pend_d = 1'b1;

    if (rd) begin
      case (ofs)
        SEG_LED_OFS:  rdata_d = {16'h0, led_q};
        SEG_DIG_OFS:  rdata_d = {16'h0, stage_q};
        SEG_CTRL_OFS: rdata_d = {24'h0, blank_q, 3'b000, en_q};
        default:      rdata_d = {29'h0, pend_q, idx_q};
      endcase
    end

    case (state_q)
      SEG_OFF: begin
        idx_d = '0;
        cnt_d = '0;
        if (en_q) begin
          state_d = SEG_DRIVE;
          commit  = 1'b1;
        end
      end
      SEG_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = SEG_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEG_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = SEG_DRIVE;
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          commit  = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SEG_OFF;
    endcase

    if (!en_q) begin
      state_d = SEG_OFF;
      idx_d   = '0;
      cnt_d   = '0;
      commit  = 1'b0;
    end

    // Commit takes the pre-write staging value; a same-cycle write stays pending.
    if (commit) begin
      active_d = stage_q;
      if (!dig_wr) pend_d = 1'b0;
    end
  end

  // Outputs are computed from the next state so an/seg line up with state_q.
  always_comb begin
    nib  = active_d[idx_d*4 +: 4];
    an_d = '1;
    seg_d = SEG_BLANK;
    if (state_d == SEG_DRIVE) begin
      seg_d = dec;
      if (!blank_q[idx_d]) an_d = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEG_OFF;
      led_q    <= '0;
      stage_q  <= '0;
      active_q <= '0;
      en_q     <= 1'b0;
      blank_q  <= '0;
      pend_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      stage_q  <= stage_d;
      active_q <= active_d;
      en_q     <= en_d;
      blank_q  <= blank_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      rdata_q  <= rdata_d;
    end
  end

  assign led   = led_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl with a short scan
// (4-cycle drive, 2-cycle gap).
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [6:0]  seg;
  logic [3:0]  an;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] rd_val;

  seg_display_ctrl #(
    .SCAN_DIV (4),
    .GAP_CYC  (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .led   (led),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // All bus tasks start and end 1ns after a rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    sel = 1'b0;
    d = rdata;
  endtask

  task automatic check_disp(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    check({tag, "_an"}, {28'h0, an}, {28'h0, exp_an});
    check({tag, "_seg"}, {25'h0, seg}, {25'h0, exp_seg});
  endtask

  // Checks drive cycles skip..3 of digit d, then its two gap cycles.
  task automatic scan_slot(input int d, input logic [6:0] sg, input bit lit, input int skip);
    logic [3:0] exp_an;
    exp_an = lit ? ~(4'b0001 << d) : 4'hF;
    for (int c = skip; c < 4; c++) begin
      @(posedge clk); #1;
      check_disp("drive", exp_an, sg);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check_disp("gap", 4'hF, 7'h7F);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_disp("reset", 4'hF, 7'h7F);
    check("reset_led", {16'h0, led}, 32'h0);
    bus_read(4'h8, rd_val);
    check("reset_ctrl", rd_val, 32'h0);

    bus_write(4'h0, 32'h0000A5A5);
    check("led_write", {16'h0, led}, 32'h0000A5A5);
    bus_read(4'h0, rd_val);
    check("led_read", rd_val, 32'h0000A5A5);

    // First frame shows 1234
    bus_write(4'h4, 32'h00001234);
    bus_write(4'h8, 32'h00000001);
    check_disp("still_off", 4'hF, 7'h7F);
    scan_slot(0, 7'h19, 1'b1, 0);
    scan_slot(1, 7'h30, 1'b1, 0);
    scan_slot(2, 7'h24, 1'b1, 0);
    scan_slot(3, 7'h79, 1'b1, 0);
    scan_slot(0, 7'h19, 1'b1, 0);
    scan_slot(1, 7'h30, 1'b1, 0);

    // New digits written while digit 2 is driven stay pending until frame end
    bus_write(4'h4, 32'h0000FFFF);
    check_disp("dig2_c0", 4'hB, 7'h24);
    bus_read(4'hC, rd_val);
    check("status_pend", rd_val, 32'h6);
    check_disp("dig2_c1", 4'hB, 7'h24);
    scan_slot(2, 7'h24, 1'b1, 2);
    scan_slot(3, 7'h79, 1'b1, 0);
    scan_slot(0, 7'h0E, 1'b1, 0);
    bus_read(4'hC, rd_val);
    check("status_clr", rd_val, 32'h0);
    bus_read(4'h4, rd_val);
    check("stage_read", rd_val, 32'h0000FFFF);

    // Blank digits 0 and 2
    bus_write(4'h8, 32'h00000050);
    bus_write(4'h8, 32'h00000051);
    check_disp("blank_off", 4'hF, 7'h7F);
    scan_slot(0, 7'h0E, 1'b0, 0);
    scan_slot(1, 7'h0E, 1'b1, 0);
    scan_slot(2, 7'h0E, 1'b0, 0);
    scan_slot(3, 7'h0E, 1'b1, 0);

    // Disable mid-drive, then restart with a fresh commit
    bus_write(4'h4, 32'h00008D6C);
    bus_write(4'h8, 32'h00000000);
    check_disp("dis_drive", 4'hF, 7'h0E);
    bus_write(4'h8, 32'h00000001);
    check_disp("dis_off", 4'hF, 7'h7F);
    scan_slot(0, 7'h46, 1'b1, 0);
    scan_slot(1, 7'h02, 1'b1, 0);
    scan_slot(2, 7'h21, 1'b1, 0);
    scan_slot(3, 7'h00, 1'b1, 0);

    bus_read(4'h8, rd_val);
    check("ctrl_read", rd_val, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check_disp("pre_rst_gap", 4'hF, 7'h7F);

    // Reset in the gap
    rst = 1'b1;
    @(posedge clk); #1;
    check_disp("rst_gap", 4'hF, 7'h7F);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    bus_read(4'h4, rd_val);
    check("rst_stage", rd_val, 32'h0);

    bus_write(4'hC, 32'hFFFFFFFF);
    bus_read(4'hC, rd_val);
    check("status_ro", rd_val, 32'h0);
    check_disp("status_ro_off", 4'hF, 7'h7F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
